// File: rtl/seq_load_sched_if.sv
// Bus between the load scheduler and its environment: run control,
// requester load port, and the datapath control/observation signals.
interface seq_load_sched_if #(
  parameter int N = 2,
  parameter int W = 16
);
  logic           start;
  logic           stop;
  logic [W-1:0]   limit;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   cnt_out;
  logic [N-1:0]   gnt;
  logic           dp_select;
  logic [W-1:0]   dp_d;
  logic           dp_clr;
  logic           busy;
  logic           done;

  modport master (
    output start, stop, limit, req, req_data, cnt_out,
    input  gnt, dp_select, dp_d, dp_clr, busy, done
  );

  modport slave (
    input  start, stop, limit, req, req_data, cnt_out,
    output gnt, dp_select, dp_d, dp_clr, busy, done
  );
endinterface

// File: rtl/seq_load_sched.sv
// Run/stop supervisor and round-robin load arbiter for a count/load datapath.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | datapath held clear, waiting for start
// RUN   | datapath counting; limit checked, then requests arbitrated
// LOAD  | granted value driven into the datapath for LOAD_CYC cycles
// DONE  | datapath frozen by reloading the captured terminal value
//
// Outputs are registered from the next-state decode, so every output
// changes on the same edge that commits the state decision.
module seq_load_sched #(
  parameter int N        = 2,
  parameter int W        = 16,
  parameter int LOAD_CYC = 3
) (
  input logic             clk,
  input logic             reset,
  seq_load_sched_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  rr_ptr, rr_nxt;
  logic [W-1:0]   ld_val, ld_nxt;
  logic [W-1:0]   hold_val, hold_nxt;
  logic [CW-1:0]  load_cnt, load_cnt_nxt;
  logic [N-1:0]   gnt_q, gnt_nxt;
  logic           sel_q, sel_nxt;
  logic [W-1:0]   d_q, d_nxt;
  logic           clr_q, clr_nxt;
  logic           busy_q, busy_nxt;
  logic           done_q, done_nxt;

  logic           found;
  logic [PW-1:0]  gidx;
  logic [PW-1:0]  cand;
  logic [W-1:0]   data_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = bus.req_data[g*W +: W];
  end

  // State, arbitration pointer, captured values and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      rr_ptr   <= PW'(N - 1);
      ld_val   <= '0;
      hold_val <= '0;
      load_cnt <= '0;
      gnt_q    <= '0;
      sel_q    <= 1'b0;
      d_q      <= '0;
      clr_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      ld_val   <= ld_nxt;
      hold_val <= hold_nxt;
      load_cnt <= load_cnt_nxt;
      gnt_q    <= gnt_nxt;
      sel_q    <= sel_nxt;
      d_q      <= d_nxt;
      clr_q    <= clr_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  // Round-robin search, next-state decision and next-output decode.
  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr_ptr;
    ld_nxt       = ld_val;
    hold_nxt     = hold_val;
    load_cnt_nxt = load_cnt;
    gnt_nxt      = '0;
    found        = 1'b0;
    gidx         = '0;
    cand         = rr_ptr;

    // Start one past the last winner so the last winner is checked last.
    for (int i = 0; i < N; i++) begin
      cand = (cand == PW'(N - 1)) ? '0 : cand + PW'(1);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.stop) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.stop) begin
          state_nxt = S_IDLE;
        end else if (bus.cnt_out >= bus.limit) begin
          state_nxt = S_DONE;
          hold_nxt  = bus.cnt_out;
        end else if (found) begin
          state_nxt     = S_LOAD;
          gnt_nxt[gidx] = 1'b1;
          rr_nxt        = gidx;
          ld_nxt        = data_arr[gidx];
          load_cnt_nxt  = CW'(LOAD_CYC - 1);
        end
      end
      S_LOAD: begin
        if (bus.stop) begin
          state_nxt = S_IDLE;
        end else if (load_cnt == '0) begin
          state_nxt = S_RUN;
        end else begin
          load_cnt_nxt = load_cnt - CW'(1);
        end
      end
      S_DONE: begin
        if (bus.start || bus.stop) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    sel_nxt  = (state_nxt == S_LOAD) || (state_nxt == S_DONE);
    clr_nxt  = (state_nxt == S_IDLE);
    busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_LOAD);
    done_nxt = (state_nxt == S_DONE);
    if (state_nxt == S_LOAD)      d_nxt = ld_nxt;
    else if (state_nxt == S_DONE) d_nxt = hold_nxt;
    else                          d_nxt = '0;
  end

  assign bus.gnt       = gnt_q;
  assign bus.dp_select = sel_q;
  assign bus.dp_d      = d_q;
  assign bus.dp_clr    = clr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_load_sched.sv
// Bench for seq_load_sched: a behavioural count/load datapath closes the
// loop, grants are checked against a queue filled when requests are driven.
module tb_seq_load_sched;

  localparam int N  = 2;
  localparam int W  = 16;
  localparam int LC = 3;

  typedef struct packed {
    logic [N-1:0] g;
    logic [W-1:0] d;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] dp_cnt = '0;
  logic [W-1:0] rd [N];
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           tb_rr = N - 1;
  exp_t         sb_q [$];
  exp_t         mon_e;
  logic [N-1:0] prev_gnt = '0;

  seq_load_sched_if #(.N(N), .W(W)) bus ();

  seq_load_sched #(.N(N), .W(W), .LOAD_CYC(LC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Count cycles for grant spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath: clear, load dp_d when selected, otherwise increment.
  always @(posedge clk) begin
    if (bus.dp_clr)         dp_cnt <= '0;
    else if (bus.dp_select) dp_cnt <= bus.dp_d;
    else                    dp_cnt <= dp_cnt + 16'd1;
  end
  assign bus.cnt_out  = dp_cnt;
  assign bus.req_data = {rd[1], rd[0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Round-robin reference: next winner after tb_rr among asserted requests.
  task automatic push_grant(input logic [N-1:0] r);
    int   k;
    exp_t e;
    k = -1;
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (tb_rr + i) % N;
      if (k < 0 && r[c]) k = c;
    end
    if (k >= 0) begin
      e.g   = N'(1) << k;
      e.d   = rd[k];
      tb_rr = k;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 20);
    chk(tag, 32'(bus.gnt != '0), 32'd1);
  endtask

  task automatic wait_done(input int budget, output int sel_bad);
    int n;
    n = 0;
    sel_bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.done && bus.dp_select) sel_bad++;
    end while (!bus.done && n < budget);
    chk("done_wait", 32'(bus.done), 32'd1);
  endtask

  // Length of the dp_select window starting at the current cycle.
  task automatic measure_load(input logic [W-1:0] exp_d, output int len, output int bad_d);
    len = 0;
    bad_d = 0;
    while (bus.dp_select && len < 10) begin
      len++;
      if (bus.dp_d !== exp_d) bad_d++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  // Scoreboard monitor: every grant pops one expectation; grants last one cycle.
  always @(negedge clk) begin
    if (prev_gnt != '0) chk("gnt_pulse", 32'(bus.gnt), 32'd0);
    if (bus.gnt != '0) begin
      if (sb_q.size() == 0) begin
        chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("gnt_order", 32'(bus.gnt), 32'(mon_e.g));
        chk("ld_data", 32'(bus.dp_d), 32'(mon_e.d));
        chk("ld_sel", 32'(bus.dp_select), 32'd1);
      end
    end
    prev_gnt = bus.gnt;
  end

  initial begin
    int sel_bad, len, bad_d, good, last;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.limit = '0;
    bus.req   = '0;
    rd[0] = '0;
    rd[1] = '0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = i[0];
      bus.req   = N'(i);
      chk("rst_clr", 32'(bus.dp_clr), 32'd1);
      chk("rst_sel", 32'(bus.dp_select), 32'd0);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
    end
    bus.start = 1'b0;
    bus.req   = '0;
    @(negedge clk);
    reset = 1'b1;
    step(3);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_clr", 32'(bus.dp_clr), 32'd1);

    // Stop dominates start in IDLE.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step(2);
    chk("stop_dom_busy", 32'(bus.busy), 32'd0);
    chk("stop_dom_clr", 32'(bus.dp_clr), 32'd1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // Count to limit 10 and freeze.
    bus.limit = 16'd10;
    pulse_start();
    chk("run_busy", 32'(bus.busy), 32'd1);
    chk("run_clr", 32'(bus.dp_clr), 32'd0);
    wait_done(40, sel_bad);
    chk("run_sel", 32'(sel_bad), 32'd0);
    chk("done_d", 32'(bus.dp_d), 32'd10);
    chk("done_sel", 32'(bus.dp_select), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    step(2);
    good = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cnt_out == 16'd10) good++;
      step(1);
    end
    chk("freeze_cnt", 32'(good), 32'd20);
    pulse_start();
    chk("exit_done", 32'(bus.done), 32'd0);
    chk("exit_clr", 32'(bus.dp_clr), 32'd1);
    step(1);
    chk("exit_cnt", 32'(bus.cnt_out), 32'd0);

    // Single load from requester 0; data change after grant is ignored.
    bus.limit = 16'hFFFF;
    pulse_start();
    step(2);
    rd[0] = 16'hA5A5;
    bus.req = 2'b01;
    push_grant(2'b01);
    wait_gnt("single_gnt");
    bus.req = '0;
    rd[0] = 16'h1234;
    measure_load(16'hA5A5, len, bad_d);
    chk("single_len", 32'(len), 32'(LC));
    chk("single_hold_d", 32'(bad_d), 32'd0);
    chk("single_cnt0", 32'(bus.cnt_out), 32'hA5A5);
    step(1);
    chk("single_cnt1", 32'(bus.cnt_out), 32'hA5A6);

    // Contention: both requesting continuously, grants alternate every 4 cycles.
    rd[0] = 16'h0100;
    rd[1] = 16'h0200;
    bus.req = 2'b11;
    repeat (4) push_grant(2'b11);
    last = 0;
    for (int g = 0; g < 4; g++) begin
      wait_gnt("cont_gnt");
      if (g > 0) chk("cont_gap", 32'(cyc - last), 32'd4);
      last = cyc;
    end
    bus.req = '0;
    measure_load(16'h0100, len, bad_d);
    chk("cont_len", 32'(len), 32'(LC));

    // Abort with stop in the second LOAD cycle.
    rd[0] = 16'h0777;
    bus.req = 2'b01;
    push_grant(2'b01);
    wait_gnt("abort_gnt");
    bus.req = '0;
    step(1);
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    chk("abort_clr", 32'(bus.dp_clr), 32'd1);
    chk("abort_sel", 32'(bus.dp_select), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    step(1);
    chk("abort_cnt", 32'(bus.cnt_out), 32'd0);

    // limit=0 with a pending request: limit wins, no grant issued.
    bus.limit = '0;
    bus.req = 2'b01;
    pulse_start();
    wait_done(10, sel_bad);
    chk("lim0_d", 32'(bus.dp_d), 32'd0);
    bus.req = '0;
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    chk("lim0_exit", 32'(bus.done), 32'd0);

    // Asynchronous reset in the middle of a load.
    bus.limit = 16'hFFFF;
    pulse_start();
    rd[0] = 16'h0BEE;
    bus.req = 2'b01;
    push_grant(2'b01);
    wait_gnt("areset_gnt");
    step(1);
    #2 reset = 1'b0;
    #1;
    chk("areset_clr", 32'(bus.dp_clr), 32'd1);
    chk("areset_sel", 32'(bus.dp_select), 32'd0);
    chk("areset_busy", 32'(bus.busy), 32'd0);
    chk("areset_gnt0", 32'(bus.gnt), 32'd0);
    tb_rr = N - 1;
    bus.req = '0;
    @(negedge clk);
    reset = 1'b1;
    step(2);

    // After reset the pointer restarts: requester 0 wins against 1.
    pulse_start();
    rd[0] = 16'h0111;
    rd[1] = 16'h0222;
    bus.req = 2'b11;
    push_grant(2'b11);
    wait_gnt("resume_gnt");
    bus.req = '0;
    measure_load(16'h0111, len, bad_d);
    chk("resume_len", 32'(len), 32'(LC));
    step(3);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
